bcd_converter_seq: RTL
======================

Name: bcd_converter_seq

Overview:
- Downstream stage of the 8-bit ALU result register. Converts the registered binary result into packed BCD digits for the seven-segment decoders (one seg7 per digit).
- Iterative shift-add-3 (double dabble) conversion: one bit per clock, with a start/busy/done handshake.
- Frees the display path from wide combinational division. Holds the last converted result stable between conversions.

Parameters:
- WIDTH, 8, bit width of the binary input (matches the ALU result width).
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_b  input  1  asynchronous active-low reset.
- start  input  1  request conversion of bin; sampled only in IDLE.
- bin  input  WIDTH  binary value to convert (normally the ALU register output).
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd has just been updated.
- bcd  output  4*DIGITS  packed BCD result, digit 0 (ones) in bits [3:0].

Behaviour:
- Reset (async, Reset_b=0): state=IDLE, busy=0, done=0, bcd=0, internal shift/scratch/count registers cleared. Takes effect immediately, including mid-conversion; the in-flight conversion is discarded and bcd stays 0.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - busy=0.
  - On start=1: latch bin into the shift register, clear scratch BCD, load count=WIDTH, go to SHIFT.
- SHIFT: busy=1. Each cycle:
  - Every scratch digit >=5 gets +3 (4-bit, no carry out).
  - Then {scratch, shift} shifts left by 1; the MSB of the shift register enters digit 0 bit 0.
  - count decrements. When count reaches 1 on this cycle, go to FINISH.
  - Exactly WIDTH SHIFT cycles are performed.
- FINISH:
  - busy=1.
  - bcd <= scratch, done=1 for this cycle only.
  - Next state IDLE.
- Latency: start sampled at edge N; done high and bcd valid after edge N+WIDTH+1 (9 cycles for WIDTH=8). Back-to-back start is accepted the cycle after done.
- start while busy (SHIFT/FINISH) is ignored, not queued.
- bin changes after the start edge do not affect the running conversion.
- bcd changes only in FINISH; otherwise it holds the last result.
- Max input (all ones, 255) yields 0x255. No digit ever exceeds 9.
- done and busy are registered outputs (no combinational path from start).

Optional Feature:
- Macro: BCD_AUTO_TRIGGER_EN.
- Defined: block keeps a last-converted copy of bin (reset 0). In IDLE, if bin != last copy, a conversion starts exactly as for start=1 and the last copy is updated at latch time. The start port still works. The display tracks the register with no external strobe.
- Undefined: conversions start only from the start port; no comparison register is built.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum (IDLE, SHIFT, FINISH) and its encoding;
  - BCD_DIGIT_W = 4;
  - default WIDTH/DIGITS constants, reused by the top-level display wiring.
- One natural sub-module: bcd_digit_adj, a combinational 4-bit "if >=5 add 3", instantiated DIGITS times in a generate loop.
- Downstream each bcd nibble feeds an existing seg7 instance.

Test Plan:
- Reset then idle: Reset_b low mid-run, then high → busy=0, done=0, bcd=0x000 immediately and held.
- bin=255, start pulse → busy for 9 cycles, done pulses once at cycle 9, bcd=0x255.
- bin=100, then bin=9 back-to-back (start the cycle after done) → bcd=0x100, then 0x009; each done exactly 9 cycles after its start.
- bin=42, start; at cycle 3 set bin=200 and pulse start → second start ignored, bcd=0x042, a single done.
- bin=0x7B (123), start; assert Reset_b=0 at cycle 5 → conversion aborted, bcd=0x000, no done. After release, start with bin=123 → bcd=0x123.
- With BCD_AUTO_TRIGGER_EN: change bin 0→57 with no start → conversion begins the next cycle, bcd=0x057. Holding bin constant produces no further done pulses.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter
// and the display wiring that consumes its packed digits.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_e;

   localparam int BCD_DIGIT_W = 4;
   localparam int DEF_WIDTH   = 8;
   localparam int DEF_DIGITS  = 3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d,
   output logic [BCD_DIGIT_W-1:0] q
);

   always_comb begin
      q = d;
      if (d >= BCD_DIGIT_W'(5)) q = d + BCD_DIGIT_W'(3);
   end

endmodule

// File: rtl/bcd_converter_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Optional macro BCD_AUTO_TRIGGER_EN: start a conversion whenever bin differs from the last one latched.
module bcd_converter_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                            Clock,
   input  logic                            Reset_b,
   input  logic                            start,
   input  logic [WIDTH-1:0]                bin,
   output logic                            busy,
   output logic                            done,
   output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd
);

   localparam int BW = BCD_DIGIT_W * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   state_e          state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]   scratch_q, scratch_d, scratch_adj;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic [CW-1:0]   count_q, count_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            trig;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .q (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

`ifdef BCD_AUTO_TRIGGER_EN
   logic [WIDTH-1:0] last_q, last_d;

   assign trig = start | (bin != last_q);

   always_comb begin
      last_d = last_q;
      if (state_q == IDLE && trig) last_d = bin;
   end

   always_ff @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) last_q <= '0;
      else          last_q <= last_d;
   end
`else
   assign trig = start;
`endif

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      count_d   = count_q;
      bcd_d     = bcd_q;
      case (state_q)
         IDLE: begin
            if (trig) begin
               shift_d   = bin;
               scratch_d = '0;
               count_d   = CW'(WIDTH);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // Correct digits first, then move the next binary MSB into digit 0.
            {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = FINISH;
         end
         FINISH: begin
            bcd_d   = scratch_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_q == FINISH);
   end

   always_ff @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         count_q   <= '0;
         bcd_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         count_q   <= count_d;
         bcd_q     <= bcd_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule
